// File: rtl/mig_frame_traffic.sv
// Frame-buffer DDR traffic controller: linear phrase writes from the camera packer,
// continuous credit-limited read prefetch of the same frame for the display unpacker.
module mig_frame_traffic #(
    parameter int FRAME_PHRASES = 115200,
    parameter int ADDR_INCR     = 8,
    parameter int BASE_ADDR     = 0,
    parameter int RD_FIFO_DEPTH = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         valid_wr_in,
    output logic         ready_wr_in,
    input  logic [127:0] data_wr_in,
    input  logic         tuser_wr_in,
    output logic         valid_rd_out,
    input  logic         ready_rd_out,
    output logic [127:0] data_rd_out,
    output logic         tuser_rd_out,
    output logic [26:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid
);
    localparam int IW = $clog2(FRAME_PHRASES);
    localparam int PW = $clog2(RD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_PHRASES - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, cmd_idx_q, cmd_idx_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [127:0]  wdata_q, wdata_d;
    logic          cmd_done_q, cmd_done_d, dat_done_q, dat_done_d;
    logic          last_wr_q, last_wr_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d;
    logic [PW-1:0] rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;

    logic [RD_FIFO_DEPTH-1:0] tag_mem;
    logic [128:0]             rsp_mem [RD_FIFO_DEPTH];

    logic rd_req, grant_wr, grant_rd, rd_accept, tag_pop, rsp_pop;

    always_comb begin
        rd_req    = credits_q < CW'(RD_FIFO_DEPTH);
        // Round-robin on a tie: the requester that lost last time wins.
        grant_wr  = !rst_in && state_q == IDLE && valid_wr_in && (!rd_req || !last_wr_q);
        grant_rd  = !rst_in && state_q == IDLE && rd_req && !grant_wr;
        rd_accept = state_q == RD && app_rdy;
        // Returns with no read outstanding (e.g. issued before a reset) are dropped.
        tag_pop   = app_rd_data_valid && tag_cnt_q != '0;
        rsp_pop   = valid_rd_out && ready_rd_out;
    end

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        cmd_idx_d  = cmd_idx_q;
        cmd_d      = cmd_q;
        wdata_d    = wdata_q;
        cmd_done_d = cmd_done_q;
        dat_done_d = dat_done_q;
        last_wr_d  = last_wr_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    cmd_idx_d  = tuser_wr_in ? '0 : wr_idx_q;
                    wr_idx_d   = (cmd_idx_d == LAST_IDX) ? '0 : cmd_idx_d + 1'b1;
                    cmd_d      = 3'b000;
                    wdata_d    = data_wr_in;
                    cmd_done_d = 1'b0;
                    dat_done_d = 1'b0;
                    last_wr_d  = 1'b1;
                    state_d    = WR;
                end else if (grant_rd) begin
                    cmd_idx_d = rd_idx_q;
                    cmd_d     = 3'b001;
                    last_wr_d = 1'b0;
                    state_d   = RD;
                end
            end
            WR: begin
                cmd_done_d = cmd_done_q | app_rdy;
                dat_done_d = dat_done_q | app_wdf_rdy;
                if (cmd_done_d && dat_done_d) state_d = IDLE;
            end
            RD: begin
                if (app_rdy) begin
                    rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        credits_d = credits_q + CW'(rd_accept) - CW'(rsp_pop);
        tag_wp_d  = tag_wp_q + PW'(rd_accept);
        tag_rp_d  = tag_rp_q + PW'(tag_pop);
        tag_cnt_d = tag_cnt_q + CW'(rd_accept) - CW'(tag_pop);
        rsp_wp_d  = rsp_wp_q + PW'(tag_pop);
        rsp_rp_d  = rsp_rp_q + PW'(rsp_pop);
        rsp_cnt_d = rsp_cnt_q + CW'(tag_pop) - CW'(rsp_pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            cmd_idx_q  <= '0;
            cmd_q      <= 3'b000;
            wdata_q    <= '0;
            cmd_done_q <= 1'b0;
            dat_done_q <= 1'b0;
            last_wr_q  <= 1'b0;
            credits_q  <= '0;
            tag_wp_q   <= '0;
            tag_rp_q   <= '0;
            tag_cnt_q  <= '0;
            rsp_wp_q   <= '0;
            rsp_rp_q   <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            cmd_idx_q  <= cmd_idx_d;
            cmd_q      <= cmd_d;
            wdata_q    <= wdata_d;
            cmd_done_q <= cmd_done_d;
            dat_done_q <= dat_done_d;
            last_wr_q  <= last_wr_d;
            credits_q  <= credits_d;
            tag_wp_q   <= tag_wp_d;
            tag_rp_q   <= tag_rp_d;
            tag_cnt_q  <= tag_cnt_d;
            rsp_wp_q   <= rsp_wp_d;
            rsp_rp_q   <= rsp_rp_d;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

    // Storage only; occupancy lives in the reset pointers above.
    always_ff @(posedge clk_in) begin
        if (rd_accept) tag_mem[tag_wp_q] <= (cmd_idx_q == '0);
        if (tag_pop)   rsp_mem[rsp_wp_q] <= {tag_mem[tag_rp_q], app_rd_data};
    end

    always_comb begin
        ready_wr_in  = grant_wr;
        app_addr     = 27'(BASE_ADDR) + 27'(cmd_idx_q) * 27'(ADDR_INCR);
        app_cmd      = cmd_q;
        app_en       = (state_q == WR && !cmd_done_q) || state_q == RD;
        app_wdf_data = wdata_q;
        app_wdf_wren = state_q == WR && !dat_done_q;
        app_wdf_end  = app_wdf_wren;
        valid_rd_out = rsp_cnt_q != '0;
        data_rd_out  = rsp_mem[rsp_rp_q][127:0];
        tuser_rd_out = rsp_mem[rsp_rp_q][128];
    end
endmodule

// File: tb/tb_mig_frame_traffic.sv
// Bench for mig_frame_traffic: MIG model with fixed read latency, scoreboards for write
// commands/data and read responses, table-driven writes and directed corner sequences.
module tb_mig_frame_traffic;
    localparam int FP    = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int NW    = 8;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         valid_wr_in, ready_wr_in, tuser_wr_in;
    logic [127:0] data_wr_in;
    logic         valid_rd_out, ready_rd_out, tuser_rd_out;
    logic [127:0] data_rd_out;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
    logic [127:0] app_wdf_data, app_rd_data;

    mig_frame_traffic #(.FRAME_PHRASES(FP), .ADDR_INCR(8), .BASE_ADDR(0), .RD_FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .valid_wr_in(valid_wr_in), .ready_wr_in(ready_wr_in), .data_wr_in(data_wr_in), .tuser_wr_in(tuser_wr_in),
        .valid_rd_out(valid_rd_out), .ready_rd_out(ready_rd_out), .data_rd_out(data_rd_out), .tuser_rd_out(tuser_rd_out),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [26:0] addr; logic [127:0] data; int due; } pend_t;
    typedef struct { logic [127:0] data; logic tuser; } rsp_t;
    typedef struct { logic [127:0] data; logic tuser; int exp_addr; } wvec_t;

    pend_t        pend_q[$];
    rsp_t         exp_rd_q[$];
    int           exp_wa_q[$];
    logic [127:0] exp_wd_q[$];
    int           rd_addr_log[$];
    logic         out_tuser_log[$];
    logic         grant_log[$];     // 1 = write command, 0 = read command
    logic [127:0] mem [FP];
    wvec_t        wvec [NW];

    int checks, failures, cyc, rd_issues, wr_en_cyc, wren_cyc;
    logic wr_hs, stray, prev_hold, prev_tuser;
    logic [127:0] prev_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe the settled cycle at negedge, then drive MIG returns after posedge.
    task automatic tick();
        rsp_t  e;
        pend_t p;
        int    ix;
        @(negedge clk_in);
        wr_hs = valid_wr_in && ready_wr_in;
        if (!rst_in) begin
            if (prev_hold) begin
                chki("hold_valid", int'(valid_rd_out), 1);
                chk("hold_data", data_rd_out, prev_data);
                chki("hold_tuser", int'(tuser_rd_out), int'(prev_tuser));
            end
            if (app_en && app_rdy && app_cmd == 3'b001) begin
                rd_issues++;
                rd_addr_log.push_back(int'(app_addr));
                grant_log.push_back(1'b0);
                ix = int'(app_addr >> 3) % FP;
                pend_q.push_back('{addr: app_addr, data: mem[ix], due: cyc + LAT});
                exp_rd_q.push_back('{data: mem[ix], tuser: (app_addr == 27'd0)});
            end
            if (app_en && app_cmd == 3'b000) wr_en_cyc++;
            if (app_en && app_rdy && app_cmd == 3'b000) begin
                grant_log.push_back(1'b1);
                if (exp_wa_q.size() == 0) chki("wr_addr_unexpected", int'(app_addr), -1);
                else chki("wr_addr", int'(app_addr), exp_wa_q.pop_front());
            end
            if (app_wdf_wren) begin
                wren_cyc++;
                chki("wdf_end", int'(app_wdf_end), 1);
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                if (exp_wd_q.size() == 0) chki("wr_data_unexpected", 1, 0);
                else chk("wr_data", app_wdf_data, exp_wd_q.pop_front());
            end
            if (valid_rd_out && ready_rd_out) begin
                if (exp_rd_q.size() == 0) chki("rd_unexpected", 1, 0);
                else begin
                    e = exp_rd_q.pop_front();
                    chk("rd_data", data_rd_out, e.data);
                    chki("rd_tuser", int'(tuser_rd_out), int'(e.tuser));
                end
                out_tuser_log.push_back(tuser_rd_out);
            end
            prev_hold  = valid_rd_out && !ready_rd_out;
            prev_data  = data_rd_out;
            prev_tuser = tuser_rd_out;
        end else prev_hold = 1'b0;
        @(posedge clk_in);
        #1;
        cyc++;
        if (stray) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            stray = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            app_rd_data_valid = 1'b1;
            app_rd_data = p.data;
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data = '0;
        end
    endtask

    task automatic do_write(input string name, input logic [127:0] d, input logic tu, input int ea);
        bit done;
        exp_wa_q.push_back(ea);
        exp_wd_q.push_back(d);
        valid_wr_in = 1'b1;
        data_wr_in  = d;
        tuser_wr_in = tu;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            tick();
            done = wr_hs;
        end
        if (!done) chki({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int   gstart, first_w, nw, idx;
        bit   seen;
        logic tu_pat [5];
        int   ad_pat [5];
        checks = 0; failures = 0; cyc = 0; rd_issues = 0; wr_en_cyc = 0; wren_cyc = 0;
        rst_in = 1'b1; valid_wr_in = 1'b0; data_wr_in = '0; tuser_wr_in = 1'b0;
        ready_rd_out = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = '0; app_rd_data_valid = 1'b0;
        stray = 1'b0; prev_hold = 1'b0; wr_hs = 1'b0; prev_data = '0; prev_tuser = 1'b0;
        for (int i = 0; i < FP; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        tu_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ad_pat = '{0, 8, 16, 24, 0};
        // Frame-start on entries 0 and 3; entry 6 is the last index, entry 7 wraps without tuser.
        wvec[0] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b1, 0};
        wvec[1] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b0, 8};
        wvec[2] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b0, 16};
        wvec[3] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b1, 0};
        wvec[4] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b0, 8};
        wvec[5] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b0, 16};
        wvec[6] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b0, 24};
        wvec[7] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b0, 0};

        repeat (2) tick();
        chki("rst_app_en", int'(app_en), 0);
        chki("rst_wdf_wren", int'(app_wdf_wren), 0);
        chki("rst_wdf_end", int'(app_wdf_end), 0);
        chki("rst_ready_wr", int'(ready_wr_in), 0);
        chki("rst_valid_rd", int'(valid_rd_out), 0);

        // Prefetch only: address sequence and frame-start tagging.
        rst_in = 1'b0;
        for (int n = 0; n < 200 && (rd_addr_log.size() < 5 || out_tuser_log.size() < 5); n++) tick();
        if (rd_addr_log.size() < 5 || out_tuser_log.size() < 5) chki("prefetch_timeout", 0, 1);
        else for (int i = 0; i < 5; i++) begin
            chki($sformatf("rd_addr%0d", i), rd_addr_log[i], ad_pat[i]);
            chki($sformatf("out_tuser%0d", i), int'(out_tuser_log[i]), int'(tu_pat[i]));
        end

        // Back-to-back writes from the table while reads stay eligible.
        gstart = grant_log.size();
        for (int i = 0; i < NW; i++) do_write($sformatf("wvec%0d", i), wvec[i].data, wvec[i].tuser, wvec[i].exp_addr);
        valid_wr_in = 1'b0;
        repeat (10) tick();
        chki("wr_addr_left", exp_wa_q.size(), 0);
        chki("wr_data_left", exp_wd_q.size(), 0);
        first_w = -1; nw = 0;
        for (int k = gstart; k < grant_log.size(); k++) if (grant_log[k] && first_w < 0) first_w = k;
        for (int k = gstart; k < grant_log.size(); k++) if (grant_log[k]) nw++;
        chki("wr_grant_count", nw, NW);
        if (first_w < 0) chki("no_wr_grant", 0, 1);
        else for (int k = first_w; k < first_w + 2 * NW - 1 && k < grant_log.size(); k++)
            chki($sformatf("grant_alt%0d", k - first_w), int'(grant_log[k]), ((k - first_w) % 2 == 0) ? 1 : 0);

        // Write data stalled three cycles with the command accepted at once.
        app_wdf_rdy = 1'b0; wr_en_cyc = 0; wren_cyc = 0;
        do_write("stall_wr", {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
        valid_wr_in = 1'b0;
        for (int n = 0; n < 20 && wren_cyc < 3; n++) tick();
        app_wdf_rdy = 1'b1;
        tick();
        chki("stall_wren_cycles", wren_cyc, 4);
        chki("stall_en_cycles", wr_en_cyc, 1);
        chki("stall_idle_wren", int'(app_wdf_wren), 0);
        chki("stall_idle_en", int'(app_en), 0);
        tick();
        chki("stall_next_rd_en", int'(app_en), 1);
        chki("stall_next_rd_cmd", int'(app_cmd), 1);

        // Reset while a read command is waiting on app_rdy.
        app_rdy = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = app_en && app_cmd == 3'b001;
        end
        if (!seen) chki("rd_wait_timeout", 0, 1);
        rst_in = 1'b1;
        tick();
        chki("midrst_app_en", int'(app_en), 0);
        chki("midrst_valid_rd", int'(valid_rd_out), 0);
        pend_q.delete(); exp_rd_q.delete();
        tick();
        pend_q.delete(); exp_rd_q.delete();
        rst_in = 1'b0;
        ready_rd_out = 1'b0;
        stray = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chki($sformatf("stray_valid%0d", i), int'(valid_rd_out), 0);
        end
        chki("restart_en", int'(app_en), 1);
        chki("restart_addr", int'(app_addr), 0);

        // Credit limit with the consumer stalled, then one pop buys one read.
        rd_issues = 0;
        idx = rd_addr_log.size();
        app_rdy = 1'b1;
        repeat (40) tick();
        chki("credit_issues", rd_issues, DEPTH);
        chki("credit_buffered", exp_rd_q.size(), DEPTH);
        chki("credit_valid", int'(valid_rd_out), 1);
        if (rd_addr_log.size() > idx) chki("restart_first_addr", rd_addr_log[idx], 0);
        else chki("restart_no_read", 0, 1);
        ready_rd_out = 1'b1;
        tick();
        ready_rd_out = 1'b0;
        repeat (20) tick();
        chki("credit_one_more", rd_issues, DEPTH + 1);

        ready_rd_out = 1'b1;
        repeat (30) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mig_frame_traffic.md
Name: mig_frame_traffic

Overview:
- Single-frame-buffer DDR traffic controller between the 128-bit write-phrase packer (camera side) and the 128-bit phrase-to-word unpacker (display side).
- Accepts write phrases with a frame-start flag and issues MIG write commands at linear frame addresses.
- Continuously prefetches the frame buffer with MIG read commands and returns read phrases in order, flagging phrase index 0 as frame start.
- Runs entirely in the MIG user-interface clock domain.

Parameters:
FRAME_PHRASES, 115200, phrases per frame (1280x720 at 16 bpp / 128); must be >= 2
ADDR_INCR, 8, app_addr step per phrase
BASE_ADDR, 0, app_addr of phrase index 0
RD_FIFO_DEPTH, 16, read response buffer depth and maximum read credits; power of 2, >= 2

Ports:
clk_in  in  1  MIG ui clock
rst_in  in  1  synchronous active-high reset
valid_wr_in  in  1  write phrase valid
ready_wr_in  out  1  write phrase accepted when valid_wr_in && ready_wr_in
data_wr_in  in  128  write phrase
tuser_wr_in  in  1  phrase starts a new frame
valid_rd_out  out  1  read phrase valid
ready_rd_out  in  1  downstream ready
data_rd_out  out  128  read phrase
tuser_rd_out  out  1  read phrase is frame index 0
app_addr  out  27  MIG address
app_cmd  out  3  3'b000 write, 3'b001 read
app_en  out  1  command valid
app_rdy  in  1  MIG command ready
app_wdf_data  out  128  write data
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  equals app_wdf_wren
app_wdf_rdy  in  1  MIG write FIFO ready
app_rd_data  in  128  read return data
app_rd_data_valid  in  1  read return valid; cannot be back-pressured

Behaviour:
- Reset: FSM = IDLE; wr_idx = 0; rd_idx = 0; credits = 0; response FIFO empty.
- Reset output values: app_en = 0, app_wdf_wren = 0, app_wdf_end = 0, ready_wr_in = 0, valid_rd_out = 0.
- Reset mid-operation: any in-flight command is abandoned. Read returns arriving while credits == 0 are dropped.
- Address mapping: app_addr = BASE_ADDR + idx*ADDR_INCR, truncated to 27 bits.
- FSM states: IDLE, WR, RD.
- IDLE: write_req = valid_wr_in; read_req = credits < RD_FIFO_DEPTH.
  - If only one request is present, it is granted.
  - If both are present, the one not granted last time wins (round-robin; last_grant resets to "read", so the first tie goes to write).
  - Write grant: ready_wr_in = 1 for that cycle (combinational, IDLE only). Latch data and the target index, go to WR.
    - Target index = 0 if tuser_wr_in, else wr_idx.
    - wr_idx next = target+1, wrapping to 0 when target == FRAME_PHRASES-1.
  - Read grant: go to RD with index rd_idx.
  - ready_wr_in = 0 in every other case and in every other state.
- WR: assert app_en (cmd 000) until accepted (app_rdy high), and app_wdf_wren/app_wdf_end with the latched data until app_wdf_rdy high.
  - Command and data completions are tracked independently with sticky flags; each signal drops the cycle after its own acceptance.
  - Return to IDLE the cycle after both are complete; this may happen in a single cycle.
- RD: assert app_en (cmd 001) with app_addr held until app_rdy high.
  - On acceptance: credits increments, rd_idx wraps at FRAME_PHRASES, and the tag (rd_idx == 0) is pushed to the tag FIFO.
  - Return to IDLE.
- Signals hold stable while waiting for rdy: app_addr, app_cmd and app_wdf_data stay constant.
- credits = reads issued, not yet returned + responses buffered.
  - Increment on read accept; decrement on output handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds RD_FIFO_DEPTH, so the response FIFO never overflows.
- Response path: app_rd_data_valid pushes the data together with the popped tag.
  - Response FIFO is first-word-fall-through: return in cycle N gives valid_rd_out in cycle N+1.
  - Simultaneous push and pop is allowed at any occupancy, including full-with-pop and empty.
- Output hold: data_rd_out and tuser_rd_out are stable while valid_rd_out && !ready_rd_out.
- Write-path corner cases:
  - tuser_wr_in mid-frame restarts the write address at index 0.
  - Write wrap without tuser continues from index 0.

Test Plan:
- Reset, then FRAME_PHRASES=4, app_rdy = app_wdf_rdy = 1, no writes, ready_rd_out = 1:
  - Reads are issued at addrs 0, 8, 16, 24, 0, ...
  - Output tuser pattern is 1, 0, 0, 0, 1.
  - Phrase data matches the model memory.
- Five writes with tuser on the 1st and 4th phrases:
  - app_addr sequence is 0, 8, 16, 0, 8.
  - app_wdf_data matches the inputs in order.
- In WR, hold app_wdf_rdy = 0 for 3 cycles while app_rdy = 1:
  - app_en drops after 1 cycle.
  - app_wdf_wren stays high for 4 cycles.
  - The FSM returns to IDLE the cycle after data acceptance.
- ready_rd_out = 0 for 40 cycles:
  - Exactly 16 reads are issued, then no more.
  - Popping one response lets exactly one more read issue.
- Continuous valid_wr_in with reads eligible:
  - Grants alternate W, R, W, R.
  - No write phrase is lost or duplicated.
- Assert rst_in during RD with app_rdy = 0:
  - The next cycle has app_en = 0 and valid_rd_out = 0.
  - A stray app_rd_data_valid is ignored.
  - After release, the read address restarts at 0.
